// File: rtl/ltl_monitor_pkg.sv
// Shared types and defaults for the LTL monitor report path.
// Record layout, default sizes and a saturating counter helper.
package ltl_monitor_pkg;

  localparam int unsigned DEF_NUM_REPORTS = 4;
  localparam int unsigned DEF_DEPTH       = 8;
  localparam int unsigned DEF_TS_W        = 16;
  localparam int unsigned SYM_W           = 8;
  localparam int unsigned CNT_W           = 8;

  typedef struct packed {
    logic [DEF_NUM_REPORTS-1:0] report;
    logic [SYM_W-1:0]           symbol;
    logic [DEF_TS_W-1:0]        ts;
  } ltl_report_rec_t;

  function automatic logic [CNT_W-1:0] sat_inc8(input logic [CNT_W-1:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/ltl_report_fifo.sv
// Generic synchronous FIFO with a registered head (valid + data) and full/empty/count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module ltl_report_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          valid_r;
  logic [W-1:0]  data_r;

  logic          pop_s;
  logic          push_s;
  logic [AW:0]   remain_s;
  logic [AW:0]   count_nxt_s;
  logic [AW-1:0] rd_ptr_nxt_s;
  logic [W-1:0]  head_nxt_s;

  // Next-state: accepted push/pop, occupancy and the record that becomes the head.
  always_comb begin
    pop_s        = rd_en && valid_r;
    push_s       = wr_en && ((count_r != FULL_CNT) || pop_s);
    remain_s     = count_r - {{AW{1'b0}}, pop_s};
    count_nxt_s  = remain_s + {{AW{1'b0}}, push_s};
    rd_ptr_nxt_s = rd_ptr_r;
    head_nxt_s   = data_r;
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    // With nothing left behind the head, a push goes straight into the head register.
    if (remain_s == {(AW+1){1'b0}}) begin
      if (push_s) begin
        head_nxt_s = wr_data;
      end else begin
        head_nxt_s = data_r;
      end
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage array write port; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s && !clear) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      valid_r  <= 1'b0;
      data_r   <= {W{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      valid_r  <= 1'b0;
      data_r   <= {W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      valid_r  <= (count_nxt_s != {(AW+1){1'b0}});
      data_r   <= head_nxt_s;
    end
  end

  assign rd_valid = valid_r;
  assign rd_data  = data_r;
  assign full     = (count_r == FULL_CNT);
  assign empty    = !valid_r;
  assign count    = count_r;

endmodule

// File: rtl/ltl_report_collector.sv
// Tags non-empty automaton reports with their triggering symbol and a timestamp,
// buffers them for the report bus, and accounts for records dropped while full.
module ltl_report_collector
  import ltl_monitor_pkg::*;
#(
  parameter int unsigned NUM_REPORTS = DEF_NUM_REPORTS,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned TS_W        = DEF_TS_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic [SYM_W-1:0]       symbols,
  input  logic [NUM_REPORTS-1:0] report_in,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_REPORTS-1:0] out_report,
  output logic [SYM_W-1:0]       out_symbol,
  output logic [TS_W-1:0]        out_ts,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned REC_W = NUM_REPORTS + SYM_W + TS_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [NUM_REPORTS-1:0] report;
    logic [SYM_W-1:0]       symbol;
    logic [TS_W-1:0]        ts;
  } rec_t;

  logic [TS_W-1:0]  ts_r;
  logic [SYM_W-1:0] sym_d_r;
  logic [TS_W-1:0]  ts_d_r;
  logic             pend_r;
  logic             overflow_r;
  logic [CNT_W-1:0] drop_count_r;

  logic             push_req_s;
  logic             pop_s;
  logic             drop_s;
  logic             fifo_wr_s;
  rec_t             wr_rec_s;
  rec_t             head_s;
  logic [REC_W-1:0] fifo_rd_data_s;
  logic             fifo_rd_valid_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [AW:0]      fifo_count_s;

  // Push/pop/drop decisions; report_in is one run-cycle behind symbols, hence sym_d/ts_d.
  always_comb begin
    push_req_s = pend_r && (|report_in);
    pop_s      = out_ready && !fifo_empty_s;
    fifo_wr_s  = push_req_s && (!fifo_full_s || pop_s);
    drop_s     = push_req_s && !pop_s && (fifo_count_s == FULL_CNT);
    wr_rec_s   = '{report: report_in, symbol: sym_d_r, ts: ts_d_r};
  end

  // Symbol/timestamp of the last accepted symbol, aligned with the registered reports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_d_r <= {SYM_W{1'b0}};
      ts_d_r  <= {TS_W{1'b0}};
    end else if (run) begin
      sym_d_r <= symbols;
      ts_d_r  <= ts_r;
    end
  end

  // Timestamp, pending-symbol flag and drop statistics; clear wins over everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_r         <= {TS_W{1'b0}};
      pend_r       <= 1'b0;
      overflow_r   <= 1'b0;
      drop_count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      ts_r         <= {TS_W{1'b0}};
      pend_r       <= 1'b0;
      overflow_r   <= 1'b0;
      drop_count_r <= {CNT_W{1'b0}};
    end else begin
      if (run) begin
        ts_r   <= ts_r + TS_W'(1);
        pend_r <= 1'b1;
      end
      if (drop_s) begin
        overflow_r   <= 1'b1;
        drop_count_r <= sat_inc8(drop_count_r);
      end
    end
  end

  ltl_report_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .wr_en    (fifo_wr_s),
    .wr_data  (wr_rec_s),
    .rd_en    (out_ready),
    .rd_valid (fifo_rd_valid_s),
    .rd_data  (fifo_rd_data_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_s)
  );

  assign head_s     = fifo_rd_data_s;
  assign out_valid  = fifo_rd_valid_s;
  assign out_report = head_s.report;
  assign out_symbol = head_s.symbol;
  assign out_ts     = head_s.ts;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_ltl_report_collector.sv
// Randomised and directed bench for ltl_report_collector against a queue-based model;
// a second instance with a 4-bit timestamp shares the stimulus to exercise wrap.
module tb_ltl_report_collector;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic [7:0] symbols;
  logic [3:0] report_in;
  logic       clear;
  logic       out_ready;

  logic        out_valid_a, overflow_a, out_valid_b, overflow_b;
  logic [3:0]  out_report_a, out_report_b;
  logic [7:0]  out_symbol_a, out_symbol_b, drop_count_a, drop_count_b;
  logic [15:0] out_ts_a;
  logic [3:0]  out_ts_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ltl_report_collector #(.NUM_REPORTS(4), .DEPTH(DEPTH), .TS_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .run(run), .symbols(symbols), .report_in(report_in),
    .clear(clear), .out_valid(out_valid_a), .out_ready(out_ready), .out_report(out_report_a),
    .out_symbol(out_symbol_a), .out_ts(out_ts_a), .overflow(overflow_a), .drop_count(drop_count_a)
  );

  ltl_report_collector #(.NUM_REPORTS(4), .DEPTH(DEPTH), .TS_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .run(run), .symbols(symbols), .report_in(report_in),
    .clear(clear), .out_valid(out_valid_b), .out_ready(out_ready), .out_report(out_report_b),
    .out_symbol(out_symbol_b), .out_ts(out_ts_b), .overflow(overflow_b), .drop_count(drop_count_b)
  );

  // Reference model: a queue of records plus the alignment/timestamp/statistics state.
  typedef struct {
    logic [3:0]  rep;
    logic [7:0]  sym;
    int unsigned ts;
  } rec_t;

  rec_t        q[$];
  int unsigned m_ts   = 0;
  int unsigned m_tsd  = 0;
  logic [7:0]  m_symd = 8'h00;
  bit          m_pend = 1'b0;
  bit          m_ovf  = 1'b0;
  int          m_drop = 0;

  always @(posedge clk or negedge reset_n) begin
    int unsigned ts_now;
    rec_t        r;
    if (!reset_n) begin
      q.delete();
      m_ts = 0; m_tsd = 0; m_symd = 8'h00; m_pend = 1'b0; m_ovf = 1'b0; m_drop = 0;
    end else begin
      ts_now = m_ts;
      if (clear) begin
        q.delete();
        m_ts = 0; m_pend = 1'b0; m_ovf = 1'b0; m_drop = 0;
      end else begin
        r.rep = report_in; r.sym = m_symd; r.ts = m_tsd;
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (m_pend && report_in != 4'h0) begin
          if (q.size() < DEPTH) q.push_back(r);
          else begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
          end
        end
        if (run) begin
          m_ts   = (m_ts + 1) % 65536;
          m_pend = 1'b1;
        end
      end
      if (run) begin
        m_symd = symbols;
        m_tsd  = ts_now;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        chk("valid_a", 32'(out_valid_a), 32'(q.size() != 0));
        chk("valid_b", 32'(out_valid_b), 32'(q.size() != 0));
        if (q.size() != 0) begin
          chk("report_a", 32'(out_report_a), 32'(q[0].rep));
          chk("symbol_a", 32'(out_symbol_a), 32'(q[0].sym));
          chk("ts_a",     32'(out_ts_a),     q[0].ts);
          chk("report_b", 32'(out_report_b), 32'(q[0].rep));
          chk("symbol_b", 32'(out_symbol_b), 32'(q[0].sym));
          chk("ts_b",     32'(out_ts_b),     q[0].ts % 16);
        end
        chk("overflow_a", 32'(overflow_a),   32'(m_ovf));
        chk("overflow_b", 32'(overflow_b),   32'(m_ovf));
        chk("drop_a",     32'(drop_count_a), 32'(m_drop));
        chk("drop_b",     32'(drop_count_b), 32'(m_drop));
      end
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] s, input logic [3:0] rp,
                       input logic rdy, input logic clr);
    run = r; symbols = s; report_in = rp; out_ready = rdy; clear = clr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, 32'({out_valid_a, out_valid_b}), 32'd0);
    chk({nm, "_report"}, 32'({out_report_a, out_report_b}), 32'd0);
    chk({nm, "_symbol"}, 32'({out_symbol_a, out_symbol_b}), 32'd0);
    chk({nm, "_ts"}, 32'({out_ts_a, out_ts_b}), 32'd0);
    chk({nm, "_stats"}, 32'({overflow_a, overflow_b, drop_count_a, drop_count_b}), 32'd0);
  endtask

  initial begin
    bit         seen_wrap;
    bit         prev_v;
    logic [3:0] prev_ts;
    int         rdy_bias;
    logic [7:0] d0;

    reset_n = 1'b0; run = 1'b0; symbols = 8'h00; report_in = 4'h0; clear = 1'b0; out_ready = 1'b0;
    fork
      compare_loop();
    join_none
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Gating: reports before any run, then run with empty reports.
    repeat (3) drive(1'b0, 8'h33, 4'hF, 1'b0, 1'b0);
    chk("gate_no_run", 32'(out_valid_a), 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'($urandom), 4'h0, 1'b0, 1'b0);
      chk("gate_zero_rep", 32'(out_valid_a), 32'd0);
    end

    // Basic record.
    do_reset();
    drive(1'b1, 8'h40, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 8'h12, 4'h0, 1'b0, 1'b0);
    chk("basic_pre_valid", 32'(out_valid_a), 32'd0);
    drive(1'b1, 8'h05, 4'b0010, 1'b0, 1'b0);
    chk("basic_valid",  32'(out_valid_a),  32'd1);
    chk("basic_report", 32'(out_report_a), 32'h2);
    chk("basic_symbol", 32'(out_symbol_a), 32'h12);
    chk("basic_ts",     32'(out_ts_a),     32'd1);
    drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    chk("basic_single", 32'(out_valid_a), 32'd0);

    // Overflow: 10 reporting cycles into 8 entries, then drain.
    do_reset();
    drive(1'b1, 8'h00, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(i + 1), 4'(i % 15 + 1), 1'b0, 1'b0);
    chk("ovf_drop",  32'(drop_count_a), 32'd2);
    chk("ovf_flag",  32'(overflow_a),   32'd1);
    chk("ovf_head_ts", 32'(out_ts_a),   32'd0);
    for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    chk("ovf_drained", 32'(out_valid_a), 32'd0);

    // Full with simultaneous pop: no drop, then one more push proves it is still full.
    for (int i = 0; i < 8; i++) drive(1'b1, 8'($urandom), 4'h4, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 4'h8, 1'b1, 1'b0);
    chk("fullpop_drop", 32'(drop_count_a), 32'd2);
    drive(1'b1, 8'h78, 4'h8, 1'b0, 1'b0);
    chk("fullpop_still_full", 32'(drop_count_a), 32'd3);

    // Clear with push and pop pending.
    drive(1'b1, 8'hAA, 4'h3, 1'b1, 1'b1);
    chk("clear_valid", 32'(out_valid_a), 32'd0);
    chk("clear_stats", 32'({overflow_a, drop_count_a}), 32'd0);
    drive(1'b1, 8'hBB, 4'h3, 1'b0, 1'b0);
    chk("clear_no_pend", 32'(out_valid_a), 32'd0);

    // Timestamp wrap on the 4-bit instance.
    do_reset();
    seen_wrap = 1'b0; prev_v = 1'b0; prev_ts = 4'h0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'($urandom), 4'h1, 1'b1, 1'b0);
      if (out_valid_b && prev_v && prev_ts == 4'hF && out_ts_b == 4'h0) seen_wrap = 1'b1;
      prev_v = out_valid_b; prev_ts = out_ts_b;
    end
    chk("ts_wrap_15_0", 32'(seen_wrap), 32'd1);

    // Asynchronous reset mid-drain.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 4'h9, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    d0 = out_symbol_a;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Randomised traffic with ready bursts and occasional clear.
    rdy_bias = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rdy_bias = $urandom_range(0, 10);
      drive($urandom_range(0, 3) != 0, 8'($urandom),
            ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
            $urandom_range(0, 9) < rdy_bias, $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ltl_report_collector.md
# ltl_report_collector

Collects the per-cycle report vector of one LTL monitor automaton cluster, tags each non-empty report with the symbol that triggered it and a free-running timestamp, and buffers the result in a small FIFO. It sits directly downstream of an automaton instance, consuming its report outputs. It hands records to the monitor's report bus over a valid/ready handshake. Records that cannot be buffered are dropped and accounted for, never silently lost.

## Interface
- NUM_REPORTS, default 4: number of automaton report wires (width of `report_in`).
- DEPTH, default 8: FIFO entries; power of two, ≥ 2.
- TS_W, default 16: timestamp width.
- clk  in  1: single clock, rising edge.
- reset_n  in  1: asynchronous, active-low reset. Assertion is immediate; deassertion is synchronised externally.
- run  in  1: symbol-valid / advance; same signal that drives the automaton.
- symbols  in  8: symbol currently presented to the automaton.
- report_in  in  NUM_REPORTS: automaton report (active_state) outputs, bit i = report node i.
- clear  in  1: synchronous flush of FIFO, counters and flags.
- out_valid  out  1: record available.
- out_ready  in  1: consumer accepts record.
- out_report  out  NUM_REPORTS: report vector of head record.
- out_symbol  out  8: triggering symbol of head record.
- out_ts  out  TS_W: timestamp of head record.
- overflow  out  1: sticky; set on any drop.
- drop_count  out  8: saturating count of dropped records.

## Operation
- Alignment:
  - Automaton report states are registered, so `report_in` in cycle n reflects the symbol accepted in the last cycle with run=1 before n.
  - The block holds `sym_d` and `ts_d`, loaded whenever run=1 with `symbols` and the current timestamp.
- Timestamp counter: TS_W bits, increments on every cycle with run=1, wraps from all-ones to 0 with no flag.
- Push condition: `|report_in` and a valid pending symbol (`pend`). `pend` is set by the first run=1 after reset or clear.
  - The entry pushed is {report_in, sym_d, ts_d}.
  - A report vector of all zeros never pushes.
- Pop: a record leaves the FIFO on a cycle with out_valid=1 and out_ready=1.
- FIFO states, tracked with a count of 0..DEPTH:
  - EMPTY: count 0.
  - PARTIAL: 0 < count < DEPTH.
  - FULL: count == DEPTH.
- Full handling:
  - Push while FULL without a pop in the same cycle: the record is dropped, overflow is set, drop_count increments and saturates at 255.
  - Push while FULL with a pop in the same cycle: the push is accepted and count stays DEPTH.
  - Push and pop together in EMPTY: impossible, because out_valid=0.
- Push and pop together in PARTIAL: count unchanged.
- clear:
  - Empties the FIFO, zeroes the timestamp, drop_count, overflow and `pend`.
  - It has priority over a push, a pop and a timestamp increment in the same cycle.
- Record order is strictly FIFO. The head record is stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: out_valid=0, out_report=0, out_symbol=0, out_ts=0, overflow=0, drop_count=0; FIFO empty, timestamp 0, `pend`=0.
- Latency: a report seen in cycle n (push accepted) gives out_valid=1 in cycle n+1, with a registered head output.
- Throughput: one push and one pop per cycle sustained.
- out_valid does not depend combinationally on out_ready; there is no ready-to-valid path.
- Reset asserted mid-stream: all state returns to reset values at once, and pending records are discarded.
- overflow and drop_count update in the cycle after the dropping push.

## Structure
- Shared package `ltl_monitor_pkg`:
  - `ltl_report_rec_t` packed struct {report, symbol, ts}.
  - Default constants for DEPTH and TS_W.
- One sub-module: `ltl_report_fifo`. It is a generic synchronous FIFO with registered outputs and full/empty/count, reused by the other cluster collectors.
- The top level holds only the alignment registers, the timestamp counter, the push/drop logic and the statistics.

## Test plan
- Basic record: after reset, run=1 with symbols 0x40, 0x12, 0x05; report_in=4'b0010 in the cycle after 0x12 -> exactly one record {0010, 0x12, ts=1}, with out_valid rising one cycle later.
- Gating:
  - report_in≠0 before any run=1 -> no record.
  - report_in=0 for 20 cycles -> out_valid stays 0.
- Overflow: DEPTH=8, out_ready=0, 10 reporting cycles -> 8 records held in order, drop_count=2, overflow=1. Then drain with out_ready=1 -> 8 records, then out_valid=0.
- Full with simultaneous pop: FIFO full, out_ready=1 during a reporting cycle -> no drop, count stays 8, drop_count unchanged.
- Wrap: TS_W=4, 18 run cycles with report every cycle -> timestamps 15 then 0 appear consecutively.
- Clear and reset:
  - clear pulsed while a push and a pop are both pending -> FIFO empty, counters 0 next cycle, no record emitted.
  - reset_n low mid-drain -> all outputs 0 immediately, without waiting for a clk edge.
